// File: rtl/pe_pkg.sv
// Shared types and sizing helpers for the PE array output drain.
// The optional checksum state is enabled by DRAIN_CHECKSUM_EN in pe_output_drain.
package pe_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CHK  = 2'd2
    } drain_state_t;

    // Bytes in one drained frame: every PE accumulator split into bytes.
    function automatic int drain_byte_count(input int m, input int n, input int width);
        return m * n * (width / BYTE_W);
    endfunction

endpackage

// File: rtl/pe_output_drain.sv
// Snapshots all PE accumulators and streams them out byte-wise over valid/ready.
// Define DRAIN_CHECKSUM_EN to append an XOR checksum byte to each frame.
//
// state | meaning
// IDLE  | waiting for drain_start; outputs quiet
// SEND  | presenting snapshot byte[counter]
// CHK   | presenting XOR of all frame bytes (DRAIN_CHECKSUM_EN only)
module pe_output_drain
    import pe_pkg::*;
#(
    parameter int M            = 2,
    parameter int N            = 2,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          drain_start,
    input  logic [M*N*OUTPUT_WIDTH-1:0]   acc_in,
    output logic                          acc_clear,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy
);

    localparam int TOTAL = drain_byte_count(M, N, OUTPUT_WIDTH);
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

    drain_state_t                   state, state_nxt;
    logic [CNT_W-1:0]               cnt;
    logic [TOTAL-1:0][BYTE_W-1:0]   snapshot;
    logic                           capture;
    logic                           last_data;
    logic                           data_hs;

    assign capture   = (state == IDLE) && drain_start;
    assign last_data = (cnt == LAST_IDX);
    assign data_hs   = (state == SEND) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (drain_start) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ready && last_data) begin
`ifdef DRAIN_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            CHK: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // acc_clear follows the capture edge so the array restarts while we drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            snapshot  <= '0;
            acc_clear <= 1'b0;
        end else begin
            acc_clear <= capture;
            if (capture) begin
                snapshot <= acc_in;
                cnt      <= '0;
            end else if (data_hs && !last_data) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DRAIN_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (capture) begin
            csum <= '0;
        end else if (data_hs) begin
            csum <= csum ^ snapshot[cnt];
        end
    end
`endif

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = snapshot[cnt];
`ifndef DRAIN_CHECKSUM_EN
                out_last  = last_data;
`endif
            end
`ifdef DRAIN_CHECKSUM_EN
            CHK: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = csum;
                out_last  = 1'b1;
            end
`endif
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule
